// File: rtl/rgb24_stream_packer.sv
// Packs 24-bit RGB pixels (byte order B,G,R) into dense 32-bit AXI4-Stream words.
// Define RGB24_PACKER_ERR_CNT_EN to add the saturating err_count line-error port.
module rgb24_stream_packer #(
  parameter logic [7:0] PAD_BYTE = 8'h00
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic [7:0]  r,
  input  logic [7:0]  g,
  input  logic [7:0]  b,
  input  logic        valid,
  input  logic        sof,
  input  logic        eol,
  output logic        in_stream_ready,
  output logic [31:0] out_stream_tdata,
  output logic [3:0]  out_stream_tkeep,
  output logic        out_stream_tlast,
  output logic        out_stream_tuser,
  output logic        out_stream_tvalid,
  input  logic        out_stream_tready
`ifdef RGB24_PACKER_ERR_CNT_EN
  ,
  output logic [15:0] err_count
`endif
);

  typedef enum logic {S_RUN, S_FLUSH} state_t;

  state_t      state_q, state_d;
  logic [1:0]  phase_q, phase_d, ph_eff;
  logic [23:0] hold_q, hold_d;
  logic        sof_pend_q, sof_pend_d, pend;
  logic        out_free, accept, load;
  logic [31:0] word_d;
  logic [3:0]  keep_d;
  logic        last_d, user_d;

  assign out_free        = !out_stream_tvalid || out_stream_tready;
  assign in_stream_ready = (state_q == S_RUN) && out_free;
  assign accept          = valid && in_stream_ready;
  // A sof pixel always starts a fresh group; leftover bytes are dropped.
  assign ph_eff          = sof ? 2'd0 : phase_q;

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    hold_d     = hold_q;
    pend       = sof_pend_q;
    sof_pend_d = sof_pend_q;
    load       = 1'b0;
    word_d     = '0;
    keep_d     = '0;
    last_d     = 1'b0;
    user_d     = 1'b0;
    if (state_q == S_RUN) begin
      if (accept) begin
        pend = sof_pend_q | sof;
        case (ph_eff)
          2'd0: begin
            if (eol) begin
              load    = 1'b1;
              word_d  = {PAD_BYTE, r, g, b};
              keep_d  = 4'b0111;
              last_d  = 1'b1;
              phase_d = 2'd0;
              hold_d  = '0;
            end else begin
              hold_d  = {r, g, b};
              phase_d = 2'd1;
            end
          end
          2'd1: begin
            load    = 1'b1;
            word_d  = {b, hold_q};
            keep_d  = 4'b1111;
            hold_d  = {8'h00, r, g};
            phase_d = 2'd2;
            if (eol) state_d = S_FLUSH;
          end
          2'd2: begin
            load    = 1'b1;
            word_d  = {g, b, hold_q[15:0]};
            keep_d  = 4'b1111;
            hold_d  = {16'h0000, r};
            phase_d = 2'd3;
            if (eol) state_d = S_FLUSH;
          end
          default: begin
            load    = 1'b1;
            word_d  = {r, g, b, hold_q[7:0]};
            keep_d  = 4'b1111;
            last_d  = eol;
            hold_d  = '0;
            phase_d = 2'd0;
          end
        endcase
      end
    end else if (out_free) begin
      // phase_q is 2 after a phase-1 eol and 3 after a phase-2 eol.
      load    = 1'b1;
      last_d  = 1'b1;
      state_d = S_RUN;
      phase_d = 2'd0;
      hold_d  = '0;
      if (phase_q == 2'd2) begin
        word_d = {PAD_BYTE, PAD_BYTE, hold_q[15:0]};
        keep_d = 4'b0011;
      end else begin
        word_d = {PAD_BYTE, PAD_BYTE, PAD_BYTE, hold_q[7:0]};
        keep_d = 4'b0001;
      end
    end
    if (load) begin
      user_d     = pend;
      sof_pend_d = 1'b0;
    end else begin
      sof_pend_d = pend;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q           <= S_RUN;
      phase_q           <= '0;
      hold_q            <= '0;
      sof_pend_q        <= 1'b0;
      out_stream_tvalid <= 1'b0;
      out_stream_tdata  <= '0;
      out_stream_tkeep  <= '0;
      out_stream_tlast  <= 1'b0;
      out_stream_tuser  <= 1'b0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      hold_q     <= hold_d;
      sof_pend_q <= sof_pend_d;
      if (load) begin
        out_stream_tvalid <= 1'b1;
        out_stream_tdata  <= word_d;
        out_stream_tkeep  <= keep_d;
        out_stream_tlast  <= last_d;
        out_stream_tuser  <= user_d;
      end else if (out_stream_tready) begin
        out_stream_tvalid <= 1'b0;
      end
    end
  end

`ifdef RGB24_PACKER_ERR_CNT_EN
  logic        sof_err, eol_err;
  logic [16:0] err_sum;

  assign sof_err = accept && sof && (phase_q != 2'd0);
  assign eol_err = accept && eol && (ph_eff != 2'd3);
  assign err_sum = {1'b0, err_count} + 17'(sof_err) + 17'(eol_err);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) err_count <= '0;
    else          err_count <= err_sum[16] ? '1 : err_sum[15:0];
  end
`endif

endmodule
